// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
// Bundles the front-panel side (1 kHz tick, raw buttons) and the datapath side
// (counter enable/clear, lap latch, display select, debug state) of the
// stopwatch control block.
//
// Signals:
//   tick_1khz  one-clk pulse at 1 kHz from the clock divider
//   btn_ss     raw start/stop button, active-high, asynchronous
//   btn_lap    raw lap button, active-high, asynchronous
//   btn_clr    raw clear button, active-high, asynchronous
//   count_en   enable to the BCD counter
//   clr_cnt    one-clk pulse clearing the BCD counter
//   latch_lap  one-clk pulse loading the lap register
//   disp_sel   0 = live count, 1 = lap register
//   state      current FSM state (debug LEDs)
//
// Modports:
//   master  the controller: consumes tick/buttons, drives the control outputs
//   slave   the surrounding board/datapath: drives tick/buttons, consumes outputs
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    logic       tick_1khz;
    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    logic       count_en;
    logic       clr_cnt;
    logic       latch_lap;
    logic       disp_sel;
    logic [1:0] state;

    modport master (
        input  tick_1khz,
        input  btn_ss,
        input  btn_lap,
        input  btn_clr,
        output count_en,
        output clr_cnt,
        output latch_lap,
        output disp_sel,
        output state
    );

    modport slave (
        output tick_1khz,
        output btn_ss,
        output btn_lap,
        output btn_clr,
        input  count_en,
        input  clr_cnt,
        input  latch_lap,
        input  disp_sel,
        input  state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Control FSM for the 8-digit stopwatch. Synchronises and debounces the three
// front-panel buttons against the 1 kHz tick, turns accepted presses into
// one-clk press pulses, and sequences the counter enable/clear and the lap
// latch / display freeze.
//
// Ports:
//   clk   system clock (50 MHz), the only clock
//   rst   synchronous active-low reset
//   bus   stopwatch_ctrl_if.master: tick_1khz, btn_ss, btn_lap, btn_clr in;
//         count_en, clr_cnt, latch_lap, disp_sel, state[1:0] out
//
// Parameter:
//   DEB_TICKS  ticks a raw level must hold before acceptance (1..255)
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DEB_TICKS = 20
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.master bus
);

    localparam logic [7:0] DEB_LIMIT = 8'(DEB_TICKS);
    localparam int         BTN_SS    = 0;
    localparam int         BTN_LAP   = 1;
    localparam int         BTN_CLR   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    logic [2:0] raw_btn;
    logic [2:0] press_vec;

    assign raw_btn = {bus.btn_clr, bus.btn_lap, bus.btn_ss};

    // -----------------------------------------------------------------------
    // Per-button synchroniser, debouncer and rising-edge press pulse
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic       sync1_q, sync1_d;
            logic       sync2_q, sync2_d;
            logic       stable_q, stable_d;
            logic       stable_dly_q, stable_dly_d;
            logic       press_q, press_d;
            logic [7:0] cnt_q, cnt_d;

            always_comb begin
                sync1_d      = raw_btn[gi];
                sync2_d      = sync1_q;
                stable_d     = stable_q;
                cnt_d        = cnt_q;
                stable_dly_d = stable_q;
                // Edge detect on the registered stable level, so the pulse
                // lands the cycle after stable rises; releases give nothing.
                press_d      = stable_q & ~stable_dly_q;

                if (sync2_q == stable_q) begin
                    // Level agrees with the accepted one: any bounce is over.
                    cnt_d = '0;
                end else if (bus.tick_1khz) begin
                    if (cnt_q + 8'd1 == DEB_LIMIT) begin
                        stable_d = sync2_q;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync1_q      <= 1'b0;
                    sync2_q      <= 1'b0;
                    stable_q     <= 1'b0;
                    stable_dly_q <= 1'b0;
                    press_q      <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    sync1_q      <= sync1_d;
                    sync2_q      <= sync2_d;
                    stable_q     <= stable_d;
                    stable_dly_q <= stable_dly_d;
                    press_q      <= press_d;
                    cnt_q        <= cnt_d;
                end
            end

            assign press_vec[gi] = press_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    state_t state_q, state_d;
    logic   clr_cnt_q, clr_cnt_d;
    logic   latch_lap_q, latch_lap_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            clr_cnt_q   <= 1'b0;
            latch_lap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            latch_lap_q <= latch_lap_d;
        end
    end

    // Each state only looks at the presses it honours, in clr > ss > lap
    // order, so a higher-priority press that is meaningless in this state
    // never masks a lower-priority one that is meaningful.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = 1'b0;
        latch_lap_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (press_vec[BTN_CLR]) begin
                    clr_cnt_d = 1'b1;
                end else if (press_vec[BTN_SS]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (press_vec[BTN_SS]) begin
                    state_d = PAUSE;
                end else if (press_vec[BTN_LAP]) begin
                    state_d     = LAP;
                    latch_lap_d = 1'b1;
                end
            end
            LAP: begin
                if (press_vec[BTN_SS]) begin
                    state_d = PAUSE;
                end else if (press_vec[BTN_LAP]) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (press_vec[BTN_CLR]) begin
                    state_d   = IDLE;
                    clr_cnt_d = 1'b1;
                end else if (press_vec[BTN_SS]) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decode only the state register.
    assign bus.state     = state_q;
    assign bus.count_en  = (state_q == RUN) || (state_q == LAP);
    assign bus.disp_sel  = (state_q == LAP);
    assign bus.clr_cnt   = clr_cnt_q;
    assign bus.latch_lap = latch_lap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl with DEB_TICKS=4 and a tick every
// 10 clk. A table of button levels with expected state/outputs drives the
// main transition coverage; hand-written sequences cover reset, bounce,
// simultaneous presses and reset during a pending debounce.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    initial forever #5 clk = ~clk;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.DEB_TICKS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw)
    );

    // 1 kHz tick model: one-clk pulse every 10 clk
    initial begin
        sw.tick_1khz = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            sw.tick_1khz = 1'b1;
            @(negedge clk);
            sw.tick_1khz = 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor: pulse high-cycle counts, state entries, pulse/state alignment
    int         clr_hi        = 0;
    int         latch_hi      = 0;
    int         run_entries   = 0;
    int         pause_entries = 0;
    int         align_err     = 0;
    logic [1:0] prev_state    = 2'b00;

    always @(negedge clk) begin
        if (sw.clr_cnt === 1'b1) begin
            clr_hi++;
            if (sw.state !== 2'b00) align_err++;
        end
        if (sw.latch_lap === 1'b1) begin
            latch_hi++;
            if (sw.state !== 2'b11 || prev_state === 2'b11) align_err++;
        end
        if (sw.state === 2'b01 && prev_state !== 2'b01) run_entries++;
        if (sw.state === 2'b10 && prev_state !== 2'b10) pause_entries++;
        prev_state = sw.state;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Advance n clk and settle just after the falling edge (monitor updated)
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_btn(input logic s, input logic l, input logic c);
        sw.btn_ss  = s;
        sw.btn_lap = l;
        sw.btn_clr = c;
    endtask

    task automatic check_outs(input string name, input logic [1:0] st,
                              input logic ce, input logic ds);
        check({name, "/state"},    int'(sw.state),    int'(st));
        check({name, "/count_en"}, int'(sw.count_en), int'(ce));
        check({name, "/disp_sel"}, int'(sw.disp_sel), int'(ds));
    endtask

    typedef struct {
        string      name;
        logic       ss;
        logic       lap;
        logic       clr;
        int         hold;
        logic [1:0] st;
        logic       ce;
        logic       ds;
        int         d_clr;
        int         d_latch;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    initial begin
        int c0, l0, r0, p0, k;

        // Table: starts in RUN with all buttons released
        vecs[0]  = '{"lap_run",     1'b0, 1'b1, 1'b0, 60, 2'b11, 1'b1, 1'b1, 0, 1};
        vecs[1]  = '{"lap_rel",     1'b0, 1'b0, 1'b0, 60, 2'b11, 1'b1, 1'b1, 0, 0};
        vecs[2]  = '{"lap_back",    1'b0, 1'b1, 1'b0, 60, 2'b01, 1'b1, 1'b0, 0, 0};
        vecs[3]  = '{"lap_rel2",    1'b0, 1'b0, 1'b0, 60, 2'b01, 1'b1, 1'b0, 0, 0};
        vecs[4]  = '{"clr_in_run",  1'b0, 1'b0, 1'b1, 60, 2'b01, 1'b1, 1'b0, 0, 0};
        vecs[5]  = '{"clr_rel",     1'b0, 1'b0, 1'b0, 60, 2'b01, 1'b1, 1'b0, 0, 0};
        vecs[6]  = '{"ss_pause",    1'b1, 1'b0, 1'b0, 60, 2'b10, 1'b0, 1'b0, 0, 0};
        vecs[7]  = '{"ss_rel",      1'b0, 1'b0, 1'b0, 60, 2'b10, 1'b0, 1'b0, 0, 0};
        vecs[8]  = '{"lap_pause",   1'b0, 1'b1, 1'b0, 60, 2'b10, 1'b0, 1'b0, 0, 0};
        vecs[9]  = '{"lap_rel3",    1'b0, 1'b0, 1'b0, 60, 2'b10, 1'b0, 1'b0, 0, 0};
        vecs[10] = '{"clr_pause",   1'b0, 1'b0, 1'b1, 60, 2'b00, 1'b0, 1'b0, 1, 0};
        vecs[11] = '{"clr_rel2",    1'b0, 1'b0, 1'b0, 60, 2'b00, 1'b0, 1'b0, 0, 0};
        vecs[12] = '{"clr_idle",    1'b0, 1'b0, 1'b1, 60, 2'b00, 1'b0, 1'b0, 1, 0};
        vecs[13] = '{"clr_rel3",    1'b0, 1'b0, 1'b0, 60, 2'b00, 1'b0, 1'b0, 0, 0};
        vecs[14] = '{"lap_idle",    1'b0, 1'b1, 1'b0, 60, 2'b00, 1'b0, 1'b0, 0, 0};
        vecs[15] = '{"lap_rel4",    1'b0, 1'b0, 1'b0, 60, 2'b00, 1'b0, 1'b0, 0, 0};
        vecs[16] = '{"ss_start",    1'b1, 1'b0, 1'b0, 60, 2'b01, 1'b1, 1'b0, 0, 0};
        vecs[17] = '{"ss_rel2",     1'b0, 1'b0, 1'b0, 60, 2'b01, 1'b1, 1'b0, 0, 0};
        vecs[18] = '{"lap_run2",    1'b0, 1'b1, 1'b0, 60, 2'b11, 1'b1, 1'b1, 0, 1};
        vecs[19] = '{"lap_rel5",    1'b0, 1'b0, 1'b0, 60, 2'b11, 1'b1, 1'b1, 0, 0};
        vecs[20] = '{"ss_in_lap",   1'b1, 1'b0, 1'b0, 60, 2'b10, 1'b0, 1'b0, 0, 0};
        vecs[21] = '{"ss_rel3",     1'b0, 1'b0, 1'b0, 60, 2'b10, 1'b0, 1'b0, 0, 0};
        vecs[22] = '{"ss_resume",   1'b1, 1'b0, 1'b0, 60, 2'b01, 1'b1, 1'b0, 0, 0};
        vecs[23] = '{"ss_rel4",     1'b0, 1'b0, 1'b0, 60, 2'b01, 1'b1, 1'b0, 0, 0};
        vecs[24] = '{"ss_pause2",   1'b1, 1'b0, 1'b0, 60, 2'b10, 1'b0, 1'b0, 0, 0};
        vecs[25] = '{"ss_rel5",     1'b0, 1'b0, 1'b0, 60, 2'b10, 1'b0, 1'b0, 0, 0};
        vecs[26] = '{"clr_pause2",  1'b0, 1'b0, 1'b1, 60, 2'b00, 1'b0, 1'b0, 1, 0};
        vecs[27] = '{"clr_rel4",    1'b0, 1'b0, 1'b0, 60, 2'b00, 1'b0, 1'b0, 0, 0};

        // ---- 1. Reset with start/stop held through reset -------------------
        set_btn(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        check_outs("reset", 2'b00, 1'b0, 1'b0);
        check("reset/clr_cnt",   int'(sw.clr_cnt),   0);
        check("reset/latch_lap", int'(sw.latch_lap), 0);
        r0 = run_entries;
        p0 = pause_entries;
        wait_clk(20);
        check("held_ss/early_state", int'(sw.state), 0);
        wait_clk(40);
        check_outs("held_ss/accepted", 2'b01, 1'b1, 1'b0);
        set_btn(1'b0, 1'b0, 1'b0);
        wait_clk(60);
        $display("txn reset_held_ss: state=%0d", sw.state);
        check("held_ss/run_entries",   run_entries - r0,   1);
        check("held_ss/pause_entries", pause_entries - p0, 0);

        // ---- Table-driven transitions (starts RUN, ends IDLE) --------------
        for (int i = 0; i < NV; i++) begin
            c0 = clr_hi;
            l0 = latch_hi;
            set_btn(vecs[i].ss, vecs[i].lap, vecs[i].clr);
            wait_clk(vecs[i].hold);
            $display("txn %s: btn ss/lap/clr=%0b%0b%0b state=%0d ce=%0b ds=%0b",
                     vecs[i].name, vecs[i].ss, vecs[i].lap, vecs[i].clr,
                     sw.state, sw.count_en, sw.disp_sel);
            check_outs(vecs[i].name, vecs[i].st, vecs[i].ce, vecs[i].ds);
            check({vecs[i].name, "/clr_cnt_cycles"},   clr_hi - c0,   vecs[i].d_clr);
            check({vecs[i].name, "/latch_lap_cycles"}, latch_hi - l0, vecs[i].d_latch);
        end

        // ---- 2. Bounce on start/stop from IDLE ------------------------------
        r0 = run_entries;
        p0 = pause_entries;
        set_btn(1'b1, 1'b0, 1'b0);
        wait_clk(20);
        set_btn(1'b0, 1'b0, 1'b0);
        wait_clk(10);
        set_btn(1'b1, 1'b0, 1'b0);
        wait_clk(28);
        check("bounce/early_state", int'(sw.state), 0);
        wait_clk(32);
        check("bounce/accepted_state", int'(sw.state), 1);
        set_btn(1'b0, 1'b0, 1'b0);
        wait_clk(60);
        $display("txn bounce: state=%0d run_entries=%0d", sw.state, run_entries - r0);
        check("bounce/run_entries",   run_entries - r0,   1);
        check("bounce/pause_entries", pause_entries - p0, 0);
        check("bounce/final_state",   int'(sw.state),     1);

        // ---- 5. Simultaneous ss+clr in PAUSE --------------------------------
        set_btn(1'b1, 1'b0, 1'b0);
        wait_clk(60);
        set_btn(1'b0, 1'b0, 1'b0);
        wait_clk(60);
        check("simul/pause_state", int'(sw.state), 2);
        c0 = clr_hi;
        r0 = run_entries;
        set_btn(1'b1, 1'b0, 1'b1);
        wait_clk(60);
        check_outs("simul/held", 2'b00, 1'b0, 1'b0);
        check("simul/clr_cnt_cycles", clr_hi - c0, 1);
        set_btn(1'b0, 1'b0, 1'b0);
        wait_clk(60);
        $display("txn simultaneous: state=%0d clr_cycles=%0d run_entries=%0d",
                 sw.state, clr_hi - c0, run_entries - r0);
        check("simul/run_entries", run_entries - r0, 0);
        check("simul/final_state", int'(sw.state),   0);

        // ---- 6. Reset during a pending lap debounce in LAP ------------------
        set_btn(1'b1, 1'b0, 1'b0);
        wait_clk(60);
        set_btn(1'b0, 1'b0, 1'b0);
        wait_clk(60);
        set_btn(1'b0, 1'b1, 1'b0);
        wait_clk(60);
        set_btn(1'b0, 1'b0, 1'b0);
        wait_clk(60);
        check("midrst/lap_state", int'(sw.state), 3);
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (sw.tick_1khz !== 1'b1 && k < 30);
        check("midrst/tick_found", int'(sw.tick_1khz === 1'b1), 1);
        @(negedge clk);
        sw.btn_lap = 1'b1;
        // Three ticks counted by the posedge before the 36th falling edge
        repeat (35) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outs("midrst/after_reset", 2'b00, 1'b0, 1'b0);
        l0 = latch_hi;
        r0 = run_entries;
        wait_clk(60);
        check("midrst/held_state", int'(sw.state), 0);
        set_btn(1'b0, 1'b0, 1'b0);
        wait_clk(60);
        set_btn(1'b0, 1'b1, 1'b0);
        wait_clk(60);
        set_btn(1'b0, 1'b0, 1'b0);
        wait_clk(60);
        $display("txn reset_mid_lap: state=%0d latch_cycles=%0d", sw.state, latch_hi - l0);
        check("midrst/final_state",  int'(sw.state), 0);
        check("midrst/latch_cycles", latch_hi - l0,  0);
        check("midrst/run_entries",  run_entries - r0, 0);

        check("pulse_alignment_errors", align_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM for the 8-digit stopwatch datapath.
- Debounces the three front-panel buttons (start/stop, lap, clear) against a 1 kHz tick from the clock divider.
- Sequences the BCD counter's enable and clear, and freezes the scanned display for lap/split readout.
- Sits between the raw board buttons and the stopwatch counter / display mux.

Parameters:
- DEB_TICKS, 20, ticks of tick_1khz a raw button level must hold before it is accepted (20 ms); legal range 1..255.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  synchronous active-low reset
- tick_1khz  input  1  one-clk-wide pulse at 1 kHz from the clock divider
- btn_ss  input  1  raw start/stop button, active-high, asynchronous
- btn_lap  input  1  raw lap button, active-high, asynchronous
- btn_clr  input  1  raw clear button, active-high, asynchronous
- count_en  output  1  enable to stopwatch BCD counter
- clr_cnt  output  1  one-clk pulse, synchronously clears counter
- latch_lap  output  1  one-clk pulse, loads lap register from live count
- disp_sel  output  1  0 = display live count, 1 = display lap register
- state  output  2  current FSM state, for debug LEDs

Behaviour:
- Reset: clk is the only clock. While rst=0 at a clk edge:
  - state=IDLE; count_en, clr_cnt, latch_lap, disp_sel all 0.
  - Sync flops, debounced levels and debounce counters cleared.
  - Any debounce in progress is discarded.
- Synchroniser: each raw button passes through a 2-FF synchroniser.
- Debounce, per button:
  - 8-bit counter and a stable level.
  - If synced level equals stable level, counter is cleared.
  - Otherwise counter increments on cycles with tick_1khz=1.
  - When the counter would reach DEB_TICKS, stable takes the synced level and the counter clears.
  - A glitch that reverts before DEB_TICKS ticks produces no change.
- Press pulse: asserts for exactly one clk, in the cycle after stable goes 0->1. Release (1->0) produces nothing.
- Simultaneous presses in one cycle: priority clr > ss > lap. Only the highest-priority press that is valid in the current state is acted on; the others are dropped.
- State encoding: IDLE=00, RUN=01, PAUSE=10, LAP=11.
- Moore outputs:
  - count_en=1 in RUN and LAP.
  - disp_sel=1 only in LAP.
- Transitions, evaluated on press pulses; the state updates at the next clk edge:
  - IDLE: ss -> RUN. clr -> IDLE with clr_cnt pulse. lap ignored.
  - RUN: ss -> PAUSE. lap -> LAP with latch_lap pulse. clr ignored.
  - LAP: lap -> RUN (display released, no latch). ss -> PAUSE. clr ignored.
  - PAUSE: ss -> RUN. clr -> IDLE with clr_cnt pulse. lap ignored.
- Pulse outputs: clr_cnt and latch_lap are registered. Each asserts for exactly one clk, in the same cycle the new state first appears on state.
- Latency: a press pulse in cycle N gives new state/outputs in cycle N+1. Minimum latency from a raw edge is 2 clk (sync) + DEB_TICKS ticks + 2 clk.
- Holding a button produces exactly one action. A new action requires release, accepted after DEB_TICKS, then a re-press.
- No counter wraps: the debounce counter clears on acceptance and cannot exceed DEB_TICKS.
- No combinational path from any input to any output.

Test Plan (DEB_TICKS=4, tick_1khz every 10 clk):
1. Reset: hold rst=0 for 3 clk with btn_ss=1. Release -> state=00, all outputs 0. btn_ss held continuously from reset is accepted once after 4 ticks -> state=01, count_en=1.
2. Bounce: btn_ss toggles high for 2 ticks, low for 1 tick, then high steadily. -> Exactly one transition IDLE->RUN, occurring 4 ticks after the final rise. No PAUSE.
3. Lap cycle, starting in RUN: press lap -> state=11, latch_lap high exactly 1 clk, disp_sel=1, count_en=1. Press lap again -> state=01, disp_sel=0, no latch_lap.
4. Pause/clear: from RUN press ss -> state=10, count_en=0. Press clr -> state=00, clr_cnt high exactly 1 clk. Separately, clr pressed in RUN -> no change, no clr_cnt.
5. Simultaneous: in PAUSE, btn_ss and btn_clr rise in the same clk and are held -> clr wins: state=00, clr_cnt pulse, and no RUN entry at any point.
6. Reset mid-operation: in LAP with a debounce count at 3, assert rst=0 for 1 clk -> state=00, disp_sel=0, count_en=0. The pending press is not acted on until the button is released and re-pressed.
